// File: rtl/silu_input_requant.sv
// -----------------------------------------------------------------------------
// silu_input_requant
//
// Streaming requantizer placed in front of the 4-bit SiLU lookup stage. Each
// lane of a wide signed fixed-point vector is rounded (half toward +inf) to
// the output fractional precision and then saturated to a signed OW-bit code
// (Q2.2 with the default parameters). There are two registered stages behind
// a valid/ready handshake.
//
// Ports:
//   clk              in   clock
//   rst              in   asynchronous active-low reset
//   data_in_0        in   packed input lanes, lane i at [i*IW +: IW]
//   data_in_0_valid  in   input beat valid
//   data_in_0_ready  out  input beat accepted this cycle (combinational)
//   data_out_0       out  packed requantized lanes, lane i at [i*OW +: OW]
//   data_out_0_valid out  output beat valid
//   data_out_0_ready in   downstream accepts
//   sat_count        out  16-bit saturating count of clamped lanes
//                         (present only with SILU_REQUANT_SAT_STATS_EN)
//
// Optional feature macro: SILU_REQUANT_SAT_STATS_EN
// -----------------------------------------------------------------------------
module silu_input_requant #(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 8,
    parameter int DATA_OUT_0_PRECISION_0 = 4,
    parameter int DATA_OUT_0_PRECISION_1 = 2,
    parameter int DATA_IN_0_PARALLELISM  = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                                                data_in_0_valid,
    output logic                                                data_in_0_ready,
    output logic [DATA_IN_0_PARALLELISM*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                                                data_out_0_valid,
    input  logic                                                data_out_0_ready
`ifdef SILU_REQUANT_SAT_STATS_EN
    ,
    output logic [15:0]                                         sat_count
`endif
);

    localparam int IW    = DATA_IN_0_PRECISION_0;
    localparam int OW    = DATA_OUT_0_PRECISION_0;
    localparam int P     = DATA_IN_0_PARALLELISM;
    localparam int SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;

    localparam int SAT_MAX_I = (1 << (OW - 1)) - 1;
    localparam int SAT_MIN_I = -(1 << (OW - 1));
    localparam logic signed [IW:0] SAT_MAX = signed'((IW + 1)'(SAT_MAX_I));
    localparam logic signed [IW:0] SAT_MIN = signed'((IW + 1)'(SAT_MIN_I));

    if (SHIFT < 0) begin : g_bad_shift
        $error("silu_input_requant: input fractional bits must be >= output fractional bits");
    end

    // Handshake / stage control
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv = !r_s2_valid || data_out_0_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    assign data_in_0_ready  = w_s1_adv;
    assign data_out_0_valid = r_s2_valid;

    // Datapath registers. Stage 1 keeps the full IW+1 bit rounded value so
    // that the rounding add can never wrap; stage 2 holds final codes.
    logic signed [IW:0]  r_s1_data [P];
    logic signed [IW:0]  w_s1_next [P];
    logic [P*OW-1:0]     r_s2_data;
    logic [P*OW-1:0]     w_s2_next;
    logic [P-1:0]        w_sat_hi;
    logic [P-1:0]        w_sat_lo;

    for (genvar g = 0; g < P; g++) begin : g_lane
        logic signed [IW:0] w_ext;
        assign w_ext = {data_in_0[g*IW + IW - 1], data_in_0[g*IW +: IW]};

        if (SHIFT > 0) begin : g_round
            localparam logic signed [IW:0] HALF = signed'((IW + 1)'(1) << (SHIFT - 1));
            logic signed [IW:0] w_sum;
            assign w_sum        = w_ext + HALF;
            assign w_s1_next[g] = w_sum >>> SHIFT;
        end else begin : g_pass
            assign w_s1_next[g] = w_ext;
        end

        assign w_sat_hi[g] = (r_s1_data[g] > SAT_MAX);
        assign w_sat_lo[g] = (r_s1_data[g] < SAT_MIN);
        assign w_s2_next[g*OW +: OW] = w_sat_hi[g] ? SAT_MAX[OW-1:0] :
                                       w_sat_lo[g] ? SAT_MIN[OW-1:0] :
                                                     r_s1_data[g][OW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            for (int unsigned i = 0; i < P; i++) begin
                r_s1_data[i] <= '0;
            end
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= data_in_0_valid;
                if (data_in_0_valid) begin
                    for (int unsigned i = 0; i < P; i++) begin
                        r_s1_data[i] <= w_s1_next[i];
                    end
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_s2_next;
                end
            end
        end
    end

    assign data_out_0 = r_s2_data;

`ifdef SILU_REQUANT_SAT_STATS_EN
    // Per-lane clamp flags travel with the stage-2 data so the counter only
    // sees beats that are actually handed downstream.
    logic [P-1:0] r_s2_sat;
    logic [15:0]  r_sat_count;
    logic [16:0]  w_cnt_sum;
    logic [15:0]  w_cnt_next;

    always_comb begin
        w_cnt_sum = {1'b0, r_sat_count};
        for (int unsigned i = 0; i < P; i++) begin
            w_cnt_sum = w_cnt_sum + {16'd0, r_s2_sat[i]};
        end
        w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_sat    <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_s2_adv && r_s1_valid) begin
                r_s2_sat <= w_sat_hi | w_sat_lo;
            end
            if (r_s2_valid && data_out_0_ready) begin
                r_sat_count <= w_cnt_next;
            end
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: doc/silu_input_requant.md
Name: silu_input_requant

Overview:
- Streaming fixed-point requantizer that sits directly upstream of the 4-bit SiLU lookup stage.
- Converts a parallel vector of wide signed fixed-point activations to signed 4-bit Q2.2 codes, the format the LUT indexes on.
- Rounds, saturates and pipelines over two registered stages behind a standard valid/ready handshake.

Parameters:
- DATA_IN_0_PRECISION_0, 16, total input width (signed two's complement).
- DATA_IN_0_PRECISION_1, 8, input fractional bits; must be >= DATA_OUT_0_PRECISION_1.
- DATA_OUT_0_PRECISION_0, 4, total output width (signed).
- DATA_OUT_0_PRECISION_1, 2, output fractional bits.
- DATA_IN_0_PARALLELISM, 4, lanes per beat; output has the same lane count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- data_in_0  in  DATA_IN_0_PARALLELISM*DATA_IN_0_PRECISION_0  packed input lanes; lane i at bits [i*W +: W].
- data_in_0_valid  in  1  input beat valid.
- data_in_0_ready  out  1  block accepts the beat this cycle.
- data_out_0  out  DATA_IN_0_PARALLELISM*DATA_OUT_0_PRECISION_0  packed requantized lanes; each lane feeds one LUT.
- data_out_0_valid  out  1  output beat valid.
- data_out_0_ready  in  1  downstream accepts.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: s1_valid=0, s2_valid=0, data_out_0_valid=0, data_out_0=0. Pipeline data registers clear to 0.
- SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1. Elaboration error if SHIFT < 0.
- Stage 1 (round), per lane:
  - Sign-extend the input to W+1 bits.
  - If SHIFT > 0: add 2^(SHIFT-1), then arithmetic right shift by SHIFT. This is round-half-toward-+inf.
  - If SHIFT == 0: pass through unchanged.
  - Register the result.
- Stage 2 (saturate), per lane:
  - Clamp to [-2^(OW-1), 2^(OW-1)-1], i.e. [-8, 7] for the defaults.
  - Register the low OW bits.
- Transfer rule: a beat moves on any cycle where valid && ready.
- Stage advance conditions:
  - s2_adv = !s2_valid || data_out_0_ready
  - s1_adv = !s1_valid || s2_adv
  - data_in_0_ready = s1_adv (combinational from data_out_0_ready; permitted).
- Stage valid updates:
  - When s1_adv: s1_valid <= data_in_0_valid.
  - When s2_adv: s2_valid <= s1_valid.
- Data registers load only when their stage advances with valid incoming data; otherwise they hold.
- Latency: 2 cycles from input handshake to data_out_0_valid with no backpressure. Throughput: 1 beat/cycle.
- data_out_0 and data_out_0_valid are driven from stage-2 registers and stay stable while valid && !ready (AXI-stream rule).
- Backpressure:
  - With data_out_0_ready low, both stages fill, then data_in_0_ready drops.
  - No beat is lost or duplicated. Order is preserved.
- Simultaneous output accept and input accept with both stages full: both stages shift in the same cycle, no bubble.
- data_in_0_valid low: bubbles propagate; s1 and s2 may each be empty independently.
- Reset asserted mid-stream:
  - Valids clear immediately (asynchronously); in-flight beats are discarded.
  - data_in_0_ready is 1 from the first cycle after reset deassertion.
- Rounding overflow cannot occur because stage 1 computes at W+1 bits; saturation alone handles range.
- Output code 4'b1000 (-2.0) is a legal saturated value.

Optional Feature:
- Macro: SILU_REQUANT_SAT_STATS_EN.
- When defined, adds port `sat_count  out  16` plus stage-2 per-lane saturation flags.
  - sat_count increments by the number of lanes that clamped in each output beat transferred (valid && ready).
  - It saturates at 16'hFFFF and resets to 0.
- When undefined: no port, no counter, no flag logic; behaviour is otherwise identical.

Test Plan:
- Defaults, all lanes 16'h0100 (1.0), ready held high -> data_out_0 lanes 4'b0100, valid exactly 2 cycles after the input handshake.
- Lanes {16'h0060, 16'hFFA0, 16'h0020, 16'hFFE0} (0.375, -0.375, 0.125, -0.125) -> lanes {4'b0010, 4'b1111, 4'b0001, 4'b0000}; confirms half-up rounding.
- Lanes {16'h0500, 16'hFD00, 16'h7FFF, 16'h8000} (5.0, -3.0, max, min) -> {4'b0111, 4'b1000, 4'b0111, 4'b1000}.
  - With SILU_REQUANT_SAT_STATS_EN defined, sat_count = 4 after the transfer.
- Stream 6 distinct beats with data_out_0_ready low for cycles 2-5:
  - data_in_0_ready low once 2 beats are held.
  - data_out_0 stable while stalled.
  - All 6 beats emerge in order.
- Continuous valid with ready toggling every cycle -> every output beat matches the reference model, no drops or duplicates, data_in_0_ready tracks s1_adv.
- Assert rst low for 1 cycle while both stages are valid -> data_out_0_valid=0 immediately, data_out_0=0, sat_count=0; the next input appears 2 cycles after its handshake.
